// File: rtl/bus_round_robin_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2
  } arb_state_e;

  localparam int MAX_MASTERS = 16;

  // Counters are one bit wider than the limit's log2 so the limit itself is representable.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/bus_round_robin_arbiter_if.sv
// Request/grant and shared transaction lines between the bus masters and the arbiter.
interface bus_round_robin_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] granted;
  logic                   begin_transactionIN;
  logic                   end_transactionIN;
  logic                   end_transactionOUT;
  logic                   bus_errorOUT;
  logic [IW-1:0]          owner;

  modport master (
    output request, begin_transactionIN, end_transactionIN,
    input  granted, end_transactionOUT, bus_errorOUT, owner
  );

  modport slave (
    input  request, begin_transactionIN, end_transactionIN,
    output granted, end_transactionOUT, bus_errorOUT, owner
  );
endinterface

// File: rtl/bus_round_robin_arbiter_picker.sv
// Combinational round-robin picker: first requester after the last winner, wrapping around.
module rr_priority_picker #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         request_i,
  input  logic [$clog2(NUM_MASTERS)-1:0] last_i,
  output logic [$clog2(NUM_MASTERS)-1:0] winner_o,
  output logic                           valid_o
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [IW-1:0] cand;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = '0;
    // Offset 1 first so the previous winner is considered last.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IW'((int'(last_i) + k) % NUM_MASTERS);
      if (!valid_o && request_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end
endmodule

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin system-bus arbiter holding the grant for a full transaction.
// Optional BUSY watchdog abort enabled by defining BUS_ARB_WATCHDOG_EN.
module bus_round_robin_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int GRANT_TIMEOUT   = 16,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  bus_round_robin_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = cnt_width(GRANT_TIMEOUT);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || GRANT_TIMEOUT < 0 ||
      WATCHDOG_CYCLES < 1) begin : g_bad_param
    $error("bus_round_robin_arbiter: parameter out of range");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] granted_q, granted_d;
  logic [IW-1:0]          owner_q, owner_d, last_q, last_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   abort_q, abort_d;
  logic [IW-1:0]          win_idx;
  logic                   win_valid;
  logic                   wd_hit;

  rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .request_i (bus.request),
    .last_i    (last_q),
    .winner_o  (win_idx),
    .valid_o   (win_valid)
  );

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int WW = cnt_width(WATCHDOG_CYCLES);
  logic [WW-1:0] wcnt_q, wcnt_d;

  // Held at zero outside BUSY, so it restarts on every entry to BUSY.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q != BUSY)   wcnt_d = '0;
    else if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end

  assign wd_hit = (state_q == BUSY) && (int'(wcnt_q) + 1 >= WATCHDOG_CYCLES);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    owner_d   = owner_q;
    last_d    = last_q;
    tcnt_d    = tcnt_q;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        granted_d = '0;
        tcnt_d    = '0;
        if (win_valid) begin
          granted_d[win_idx] = 1'b1;
          owner_d            = win_idx;
          last_d             = win_idx;
          state_d            = GRANTED;
        end
      end
      GRANTED: begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
        if (bus.begin_transactionIN) begin
          if (bus.end_transactionIN) begin
            granted_d = '0;
            state_d   = IDLE;
          end else begin
            state_d   = BUSY;
          end
        end else if (!bus.request[owner_q]) begin
          granted_d = '0;
          state_d   = IDLE;
        end else if (GRANT_TIMEOUT != 0 && int'(tcnt_q) + 1 >= GRANT_TIMEOUT) begin
          // Pointer keeps the stalled master, sending it to the back of the queue.
          granted_d = '0;
          state_d   = IDLE;
        end
      end
      BUSY: begin
        if (bus.end_transactionIN) begin
          granted_d = '0;
          state_d   = IDLE;
        end else if (wd_hit) begin
          granted_d = '0;
          abort_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        granted_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      granted_q <= '0;
      owner_q   <= '0;
      last_q    <= IW'(NUM_MASTERS - 1);
      tcnt_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tcnt_q    <= tcnt_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.granted            = granted_q;
  assign bus.owner              = owner_q;
  assign bus.end_transactionOUT = abort_q;
  assign bus.bus_errorOUT       = abort_q;
endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for corner cases, random traffic vs model.
module tb_bus_round_robin_arbiter;
  localparam int N  = 4;
  localparam int GT = 16;
  localparam int WD = 8;
`ifdef BUS_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  bus_round_robin_arbiter_if #(.NUM_MASTERS(N)) bus ();

  bus_round_robin_arbiter #(
    .NUM_MASTERS(N), .GRANT_TIMEOUT(GT), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock_i (clk),
    .reset_i (rst_b),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = no owner, 1 = granted waiting for begin, 2 = transaction running.
  int m_phase, m_grant, m_owner, m_last, m_wait, m_busy;
  bit m_abort;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_release();
    m_grant = -1;
    m_phase = 0;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] q, input logic b, input logic e);
    bit found;
    int c;
    m_abort = 1'b0;
    if (!r) begin
      m_phase = 0; m_grant = -1; m_last = N - 1; m_owner = 0; m_wait = 0; m_busy = 0;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && q[c]) begin
          found = 1'b1;
          m_grant = c; m_owner = c; m_last = c; m_phase = 1; m_wait = 0;
        end
      end
    end else if (m_phase == 1) begin
      m_wait++;
      if (b) begin
        if (e) model_release();
        else begin m_phase = 2; m_busy = 0; end
      end else if (!q[m_owner]) model_release();
      else if (GT != 0 && m_wait >= GT) model_release();
    end else begin
      if (e) model_release();
      else begin
        m_busy++;
        if (WD_ON && m_busy >= WD) begin
          model_release();
          m_abort = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] q, input logic b, input logic e);
    int exp_gnt;
    rst_b = r;
    bus.request = q;
    bus.begin_transactionIN = b;
    bus.end_transactionIN = e;
    model_step(r, q, b, e);
    @(posedge clk);
    #1;
    exp_gnt = (m_grant < 0) ? 0 : (1 << m_grant);
    check("model_granted", int'(bus.granted), exp_gnt);
    check("model_owner", int'(bus.owner), m_owner);
    check("model_end_out", int'(bus.end_transactionOUT), int'(m_abort));
    check("model_bus_error", int'(bus.bus_errorOUT), int'(m_abort));
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         b;
    logic         e;
    logic [N-1:0] gnt;
    int           own;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "time limit reached");
  end

  initial begin
    logic [N-1:0] rq;
    logic rr, rb, re;

    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1};
    tbl[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1};
    tbl[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 2};
    tbl[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 2};
    tbl[9]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 3};
    tbl[10] = '{4'b1111, 1'b1, 1'b0, 4'b1000, 3};
    tbl[11] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 3};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 0};
    tbl[13] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 0};
    tbl[14] = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1};

    rst_b = 1'b0;
    bus.request = '0;
    bus.begin_transactionIN = 1'b0;
    bus.end_transactionIN = 1'b0;

    // Reset state
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    check("reset_granted", int'(bus.granted), 0);
    check("reset_owner", int'(bus.owner), 0);
    check("reset_end_out", int'(bus.end_transactionOUT), 0);

    // Rotation, single-beat transaction, request drop while granted
    for (int i = 0; i < 17; i++) begin
      step(1'b1, tbl[i].req, tbl[i].b, tbl[i].e);
      check("tbl_granted", int'(bus.granted), int'(tbl[i].gnt));
      check("tbl_owner", int'(bus.owner), tbl[i].own);
    end

    // Grant timeout: stalled master 2 loses the grant after GT cycles, then goes to the back
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 1; i <= GT + 1; i++) begin
      step(1'b1, 4'b0100, 1'b0, 1'b0);
      check("timeout_granted", int'(bus.granted), (i <= GT) ? 4 : 0);
    end
    step(1'b1, 4'b0101, 1'b0, 1'b0);
    check("after_timeout_granted", int'(bus.granted), 1);

    // Owner drops request while BUSY: grant held until end
    step(1'b1, 4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      check("busy_hold_granted", int'(bus.granted), 1);
    end
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    check("busy_end_granted", int'(bus.granted), 0);

    // Long BUSY: watchdog abort in that build, indefinite hold otherwise
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    check("wd_grant", int'(bus.granted), 2);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      if (WD_ON) begin
        check("wd_granted", int'(bus.granted), (i < WD) ? 2 : 0);
        check("wd_error", int'(bus.bus_errorOUT), (i == WD) ? 1 : 0);
      end else begin
        check("nowd_granted", int'(bus.granted), 2);
        check("nowd_error", int'(bus.bus_errorOUT), 0);
      end
    end
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    check("wd_final_granted", int'(bus.granted), 0);

    // Reset during BUSY drops the grant and restores the pointer
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b1, 1'b0);
    check("rst_busy_granted", int'(bus.granted), 4);
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    check("rst_mid_granted", int'(bus.granted), 0);
    check("rst_mid_owner", int'(bus.owner), 0);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    check("rst_then_granted", int'(bus.granted), 1);

    // Random traffic against the model
    rq = 4'b1010;
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
      rr = ($urandom_range(0, 99) != 0);
      rb = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 4) == 0);
      step(rr, rq, rb, re);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
